ctrl_stage_pipe: RTL and testbench
==================================

# ctrl_stage_pipe

Carries the decoded control bundle from the main decoder through the ID/EX, EX/MEM and MEM/WB pipeline boundaries, inserting bubbles on load-use hazards and on control-transfer flushes. It sits between the combinational opcode decoder and the EX/MEM/WB datapath. It emits the per-stage control signals and the stall request for the PC and IF/ID registers. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_reg_wb_src  in  2  decoded write-back source (00 ALU, 01 memory, 10 PC+4)
- id_reg_write, id_mem_read, id_mem_write, id_ALU_src  in  1 each  decoded controls for the instruction in ID
- id_ALU_ctrl_op  in  2  decoded ALU class
- id_ctrl_transfer  in  2  decoded transfer type: 00 JAL, 01 JALR, 10 BRANCH, 11 none
- id_rd, id_rs1, id_rs2  in  5 each  register indices of the instruction in ID
- flush  in  1  taken transfer resolved in EX; kill the instruction entering EX
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_reg_wb_src, ex_ALU_ctrl_op, ex_ctrl_transfer  out  2 each  ID/EX register contents
- ex_reg_write, ex_mem_read, ex_mem_write, ex_ALU_src  out  1 each  ID/EX register contents
- ex_rd  out  5  ID/EX destination register
- mem_reg_wb_src  out  2  EX/MEM register contents
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  EX/MEM register contents
- mem_rd  out  5  EX/MEM destination register
- wb_reg_wb_src  out  2  MEM/WB register contents
- wb_reg_write  out  1  MEM/WB register contents
- wb_rd  out  5  MEM/WB destination register
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Bubble definition: all 1-bit controls are 0, all 2-bit fields are 00, and rd is 0. The exception is ctrl_transfer, which is 11 (none).
- Load-use hazard detection:
  - stall = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Detection is purely combinational from the ID/EX register and the ID inputs.
- ID/EX next-state priority:
  1. reset: bubble.
  2. flush: bubble.
  3. stall: bubble.
  4. Otherwise: capture all id_* inputs.
- When id_rd == 0, id_reg_write is captured as 0, so no write to x0 propagates.
- EX/MEM always advances from ID/EX: wb_src, reg_write, mem_read, mem_write, rd.
- MEM/WB always advances from EX/MEM: wb_src, reg_write, rd.
- There is no back-end stall in this block.
- flush does not suppress stall. The stall output is still driven from the current state, and the upstream hold is the fetch unit's concern.
- stall_cnt increments on each cycle with stall=1.
- flush_cnt increments on each cycle with flush=1.
- Both counters saturate at all-ones (2^CNT_W−1) and never wrap.
- Both counters increment in the same cycle when stall and flush coincide.

## Timing
- Reset values: all ex_/mem_/wb_ outputs are bubble values, with ex_ctrl_transfer=11. stall=0 and both counters are 0.
- An instruction is visible on ex_* one cycle after it is presented on id_*, on mem_* after two cycles, and on wb_* after three.
- A stall lasts exactly one cycle per load. The bubble clears ex_mem_read, so stall deasserts the next cycle unless a new load is captured.
- A flush on cycle N places a bubble on ex_* at N+1. The bubble propagates to mem_* at N+2 and wb_* at N+3.
- Reset asserted mid-stream overrides flush and stall. All three stage registers become bubbles on the next edge.

## Test plan
- Reset: hold reset for 2 cycles with random id_* values. Required: all outputs at bubble values, ex_ctrl_transfer=11, counters 0.
- Pass-through: present an OP with rd=5, reg_write=1, ALU_ctrl_op=01, then idle bubbles. Required: ex_rd=5 at +1, mem_rd=5 at +2, wb_rd=5 with wb_reg_write=1 at +3.
- Load-use: present a LOAD with rd=7, then an instruction with rs2=7. Required:
  - stall=1 for exactly one cycle, and ex_* is a bubble the following cycle.
  - stall_cnt=1.
  - The dependent instruction enters EX one cycle later.
- x0 guard:
  - A LOAD with rd=0 followed by rs1=0 gives stall=0.
  - An OP with rd=0 and reg_write=1 gives ex_reg_write=0.
- Flush: assert flush with a valid JAL (ctrl_transfer=00) on id_*. Required: ex_ctrl_transfer=11, ex_reg_write=0, flush_cnt=1.
- Saturation: with CNT_W=4, assert flush for 20 cycles. Required: flush_cnt stops at 15 and holds.

Source files
------------

// File: rtl/ctrl_stage_pipe_if.sv
// Control-bundle bus between the opcode decoder / EX-MEM-WB datapath (master)
// and the control-stage pipeline (slave).
interface ctrl_stage_pipe_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       id_reg_wb_src;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_ALU_src;
    logic [1:0]       id_ALU_ctrl_op;
    logic [1:0]       id_ctrl_transfer;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             flush;

    logic             stall;

    logic [1:0]       ex_reg_wb_src;
    logic [1:0]       ex_ALU_ctrl_op;
    logic [1:0]       ex_ctrl_transfer;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_ALU_src;
    logic [4:0]       ex_rd;

    logic [1:0]       mem_reg_wb_src;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic [4:0]       mem_rd;

    logic [1:0]       wb_reg_wb_src;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_reg_wb_src, id_reg_write, id_mem_read, id_mem_write, id_ALU_src,
               id_ALU_ctrl_op, id_ctrl_transfer, id_rd, id_rs1, id_rs2, flush,
        input  stall,
               ex_reg_wb_src, ex_ALU_ctrl_op, ex_ctrl_transfer, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_ALU_src, ex_rd,
               mem_reg_wb_src, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd,
               wb_reg_wb_src, wb_reg_write, wb_rd,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_reg_wb_src, id_reg_write, id_mem_read, id_mem_write, id_ALU_src,
               id_ALU_ctrl_op, id_ctrl_transfer, id_rd, id_rs1, id_rs2, flush,
        output stall,
               ex_reg_wb_src, ex_ALU_ctrl_op, ex_ctrl_transfer, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_ALU_src, ex_rd,
               mem_reg_wb_src, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd,
               wb_reg_wb_src, wb_reg_write, wb_rd,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_stage_pipe.sv
// Control-bundle pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubble
// insertion, flush bubbles and saturating stall/flush event counters.
module ctrl_stage_pipe #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    ctrl_stage_pipe_if.slave  bus
);

    typedef struct packed {
        logic [1:0] wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] xfer;
        logic [4:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic [1:0] wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic [1:0] wb_src;
        logic       reg_write;
        logic [4:0] rd;
    } wb_ctrl_t;

    // A bubble is all-zero except the transfer type, which reads as "none".
    localparam ex_ctrl_t EX_BUBBLE = '{
        wb_src: 2'b00, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        alu_src: 1'b0, alu_op: 2'b00, xfer: 2'b11, rd: 5'd0
    };
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

    ex_ctrl_t  ex_reg, ex_next, id_bundle;
    mem_ctrl_t mem_reg, mem_next;
    wb_ctrl_t  wb_reg, wb_next;
    logic      stall_next;

    // Load-use detection looks only at the ID/EX register and the ID operands.
    always_comb begin
        stall_next = ex_reg.mem_read && (ex_reg.rd != 5'd0) &&
                     ((ex_reg.rd == bus.id_rs1) || (ex_reg.rd == bus.id_rs2));
    end

    always_comb begin
        id_bundle           = EX_BUBBLE;
        id_bundle.wb_src    = bus.id_reg_wb_src;
        id_bundle.reg_write = bus.id_reg_write && (bus.id_rd != 5'd0);
        id_bundle.mem_read  = bus.id_mem_read;
        id_bundle.mem_write = bus.id_mem_write;
        id_bundle.alu_src   = bus.id_ALU_src;
        id_bundle.alu_op    = bus.id_ALU_ctrl_op;
        id_bundle.xfer      = bus.id_ctrl_transfer;
        id_bundle.rd        = bus.id_rd;
    end

    always_comb begin
        ex_next = id_bundle;
        if (bus.flush || stall_next) begin
            ex_next = EX_BUBBLE;
        end
    end

    always_comb begin
        mem_next           = MEM_BUBBLE;
        mem_next.wb_src    = ex_reg.wb_src;
        mem_next.reg_write = ex_reg.reg_write;
        mem_next.mem_read  = ex_reg.mem_read;
        mem_next.mem_write = ex_reg.mem_write;
        mem_next.rd        = ex_reg.rd;
    end

    always_comb begin
        wb_next           = WB_BUBBLE;
        wb_next.wb_src    = mem_reg.wb_src;
        wb_next.reg_write = mem_reg.reg_write;
        wb_next.rd        = mem_reg.rd;
    end

    // No back-end stall: the later stages advance every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_reg  <= EX_BUBBLE;
            mem_reg <= MEM_BUBBLE;
            wb_reg  <= WB_BUBBLE;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= mem_next;
            wb_reg  <= wb_next;
        end
    end

    logic [1:0]         cnt_event;
    logic [2*CNT_W-1:0] cnt_flat;

    assign cnt_event = {bus.flush, stall_next};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign bus.stall            = stall_next;

    assign bus.ex_reg_wb_src    = ex_reg.wb_src;
    assign bus.ex_ALU_ctrl_op   = ex_reg.alu_op;
    assign bus.ex_ctrl_transfer = ex_reg.xfer;
    assign bus.ex_reg_write     = ex_reg.reg_write;
    assign bus.ex_mem_read      = ex_reg.mem_read;
    assign bus.ex_mem_write     = ex_reg.mem_write;
    assign bus.ex_ALU_src       = ex_reg.alu_src;
    assign bus.ex_rd            = ex_reg.rd;

    assign bus.mem_reg_wb_src   = mem_reg.wb_src;
    assign bus.mem_reg_write    = mem_reg.reg_write;
    assign bus.mem_mem_read     = mem_reg.mem_read;
    assign bus.mem_mem_write    = mem_reg.mem_write;
    assign bus.mem_rd           = mem_reg.rd;

    assign bus.wb_reg_wb_src    = wb_reg.wb_src;
    assign bus.wb_reg_write     = wb_reg.reg_write;
    assign bus.wb_rd            = wb_reg.rd;

    assign bus.stall_cnt        = cnt_flat[CNT_W-1:0];
    assign bus.flush_cnt        = cnt_flat[2*CNT_W-1:CNT_W];

endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// Randomized + directed bench for ctrl_stage_pipe against a stage-history
// reference model; counters use a narrow width so saturation is reachable.
module tb_ctrl_stage_pipe;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_stage_pipe_if #(.CNT_W(CNT_W)) bus ();

    ctrl_stage_pipe #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] xfer;
        logic [4:0] rd;
    } ctl_t;

    localparam ctl_t BUB = '{
        wb_src: 2'b00, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        alu_src: 1'b0, alu_op: 2'b00, xfer: 2'b11, rd: 5'd0
    };

    ctl_t       cur;
    logic [4:0] cur_rs1, cur_rs2;
    logic       cur_flush, cur_rst;

    // Model: contents of the instruction held in each stage plus event counts.
    ctl_t m_ex, m_mem, m_wb;
    int   m_sc, m_fc;
    logic stall_seen;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        cur = BUB; cur_rs1 = 5'd0; cur_rs2 = 5'd0; cur_flush = 1'b0; cur_rst = 1'b0;
    endtask

    task automatic set_random();
        cur.wb_src    = 2'($urandom_range(0, 2));
        cur.reg_write = 1'($urandom_range(0, 1));
        cur.mem_read  = ($urandom_range(0, 2) == 0);
        cur.mem_write = 1'($urandom_range(0, 1));
        cur.alu_src   = 1'($urandom_range(0, 1));
        cur.alu_op    = 2'($urandom_range(0, 3));
        cur.xfer      = 2'($urandom_range(0, 3));
        cur.rd        = 5'($urandom_range(0, 3));
        cur_rs1       = 5'($urandom_range(0, 3));
        cur_rs2       = 5'($urandom_range(0, 3));
        cur_flush     = ($urandom_range(0, 7) == 0);
        cur_rst       = ($urandom_range(0, 39) == 0);
    endtask

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    task automatic step();
        logic ms;
        ctl_t cap;
        ctl_t obs;
        @(negedge clk);
        reset                = cur_rst;
        bus.flush            = cur_flush;
        bus.id_reg_wb_src    = cur.wb_src;
        bus.id_reg_write     = cur.reg_write;
        bus.id_mem_read      = cur.mem_read;
        bus.id_mem_write     = cur.mem_write;
        bus.id_ALU_src       = cur.alu_src;
        bus.id_ALU_ctrl_op   = cur.alu_op;
        bus.id_ctrl_transfer = cur.xfer;
        bus.id_rd            = cur.rd;
        bus.id_rs1           = cur_rs1;
        bus.id_rs2           = cur_rs2;
        #1;
        ms = m_ex.mem_read && (m_ex.rd != 5'd0) && ((m_ex.rd == cur_rs1) || (m_ex.rd == cur_rs2));
        stall_seen = bus.stall;
        chk("stall", 32'(bus.stall), 32'(ms));

        @(posedge clk);
        #1;
        if (cur_rst) begin
            m_ex = BUB; m_mem = BUB; m_wb = BUB; m_sc = 0; m_fc = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (ms)        m_sc = sat_inc(m_sc);
            if (cur_flush) m_fc = sat_inc(m_fc);
            if (cur_flush || ms) begin
                m_ex = BUB;
            end else begin
                cap           = cur;
                cap.reg_write = cur.reg_write && (cur.rd != 5'd0);
                m_ex          = cap;
            end
        end
        cyc++;

        obs = '{wb_src: bus.ex_reg_wb_src, reg_write: bus.ex_reg_write,
                mem_read: bus.ex_mem_read, mem_write: bus.ex_mem_write,
                alu_src: bus.ex_ALU_src, alu_op: bus.ex_ALU_ctrl_op,
                xfer: bus.ex_ctrl_transfer, rd: bus.ex_rd};
        chk("ex_stage", 32'(obs), 32'(m_ex));
        chk("mem_stage",
            32'({bus.mem_reg_wb_src, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_rd}),
            32'({m_mem.wb_src, m_mem.reg_write, m_mem.mem_read, m_mem.mem_write, m_mem.rd}));
        chk("wb_stage",
            32'({bus.wb_reg_wb_src, bus.wb_reg_write, bus.wb_rd}),
            32'({m_wb.wb_src, m_wb.reg_write, m_wb.rd}));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fc));

        $display("cyc %0d rst=%0b flush=%0b stall=%0b ex_rd=%0d mem_rd=%0d wb_rd=%0d scnt=%0d fcnt=%0d",
                 cyc, cur_rst, cur_flush, stall_seen, bus.ex_rd, bus.mem_rd, bus.wb_rd,
                 bus.stall_cnt, bus.flush_cnt);
    endtask

    task automatic do_reset();
        set_idle();
        cur_rst = 1'b1;
        step();
        cur_rst = 1'b0;
    endtask

    initial begin
        m_ex = BUB; m_mem = BUB; m_wb = BUB; m_sc = 0; m_fc = 0;

        // Reset held for two cycles with random decoded inputs.
        for (int i = 0; i < 2; i++) begin
            set_random();
            cur_rst = 1'b1;
            step();
        end
        chk("rst_xfer", 32'(bus.ex_ctrl_transfer), 32'd3);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);

        // Pass-through of an ALU op with rd=5.
        set_idle();
        cur.reg_write = 1'b1; cur.alu_op = 2'b01; cur.rd = 5'd5;
        cur_rs1 = 5'd1; cur_rs2 = 5'd2;
        step();
        chk("pt_ex_rd", 32'(bus.ex_rd), 32'd5);
        set_idle();
        step();
        chk("pt_mem_rd", 32'(bus.mem_rd), 32'd5);
        step();
        chk("pt_wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("pt_wb_rw", 32'(bus.wb_reg_write), 32'd1);

        // Load-use: LOAD rd=7 then consumer with rs2=7.
        do_reset();
        set_idle();
        cur.wb_src = 2'b01; cur.reg_write = 1'b1; cur.mem_read = 1'b1;
        cur.alu_src = 1'b1; cur.rd = 5'd7;
        step();
        set_idle();
        cur.reg_write = 1'b1; cur.rd = 5'd8; cur_rs1 = 5'd3; cur_rs2 = 5'd7;
        step();
        chk("lu_stall_on", 32'(stall_seen), 32'd1);
        chk("lu_ex_bubble_rd", 32'(bus.ex_rd), 32'd0);
        chk("lu_ex_bubble_mr", 32'(bus.ex_mem_read), 32'd0);
        step();
        chk("lu_stall_off", 32'(stall_seen), 32'd0);
        chk("lu_dep_in_ex", 32'(bus.ex_rd), 32'd8);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // x0 guard.
        set_idle();
        cur.mem_read = 1'b1; cur.reg_write = 1'b1; cur.rd = 5'd0;
        step();
        set_idle();
        step();
        chk("x0_no_stall", 32'(stall_seen), 32'd0);
        set_idle();
        cur.reg_write = 1'b1; cur.rd = 5'd0;
        step();
        chk("x0_no_write", 32'(bus.ex_reg_write), 32'd0);

        // Flush with a valid JAL in ID.
        do_reset();
        set_idle();
        cur.xfer = 2'b00; cur.wb_src = 2'b10; cur.reg_write = 1'b1; cur.rd = 5'd1;
        cur_flush = 1'b1;
        step();
        chk("fl_xfer", 32'(bus.ex_ctrl_transfer), 32'd3);
        chk("fl_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("fl_cnt", 32'(bus.flush_cnt), 32'd1);

        // Saturation: 20 flush cycles on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_random();
            cur_rst   = 1'b0;
            cur_flush = 1'b1;
            step();
        end
        chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'(SAT));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            set_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
